flow_average: RTL and testbench
===============================

FLOW_AVERAGE -- requirements
Module: flow_average

Interface
REQ-001 Parameter IMG_WIDTH, default 64, pixels per row.
REQ-002 Parameter IMG_HEIGHT, default 64, rows per frame.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset, named clk and reset; reset is asserted when low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous active-low reset.
REQ-006 recv_msg  input  64  flow vector from the core stage: {v[63:32], u[31:0]}, each signed Q20.12, raster order.
REQ-007 recv_val  input  1  recv_msg valid.
REQ-008 recv_rdy  output  1  block accepts recv_msg this cycle.
REQ-009 send_msg  output  64  neighbour-averaged flow {v_avg, u_avg}, same format, for the core stage's uv input.
REQ-010 send_val  output  1  send_msg valid.
REQ-011 send_rdy  input  1  consumer accepts send_msg.

Function
REQ-012 The block SHALL transfer an input only when recv_val and recv_rdy are both high, and an output only when send_val and send_rdy are both high.
REQ-013 The block SHALL compute, for each pixel p=(r,c), u_avg=(u_up+u_dn+u_lt+u_rt)>>>2, and v_avg likewise; sums are 34-bit signed, the shift is arithmetic, and the result is truncated to 32 bits.
REQ-014 Any neighbour outside the frame SHALL be replaced by the centre value of p (replicate border).
REQ-015 The block SHALL implement FSM states FILL, RUN and DRAIN, with reset state FILL.
REQ-016 FILL: recv_rdy=1 and no output; after the 65th accepted input (index 64), the FSM goes to RUN.
REQ-017 RUN: accepting input k generates the output for pixel k-65, registered so that send_val rises the following cycle.
REQ-018 Output register: recv_rdy = !send_val || send_rdy in RUN; a held send_msg SHALL stay stable while send_val=1 and send_rdy=0.
REQ-019 After input IMG_WIDTH*IMG_HEIGHT-1 is accepted, the FSM SHALL enter DRAIN; there recv_rdy=0 and the remaining 65 outputs are emitted, at most one per cycle, as send_rdy allows, with missing down neighbours replicated.
REQ-020 After the final output handshake, the FSM SHALL return to FILL with all counters cleared, ready for the next frame.
REQ-021 History SHALL hold the latest 129 accepted samples in a circular buffer; the write pointer wraps from 128 to 0.
REQ-022 Row and column counters SHALL track the output pixel; the column wraps at IMG_WIDTH-1 and the frame ends at row IMG_HEIGHT-1.
REQ-023 Exactly IMG_WIDTH*IMG_HEIGHT outputs SHALL be emitted per frame, in raster order, with no loss or duplication under any backpressure.

Reset
REQ-024 While reset=0 at a clock edge: send_val=0, send_msg=0, FSM=FILL, all pointers and counters=0, and recv_rdy=1 on the first cycle after release.
REQ-025 Reset mid-frame SHALL discard the partial frame; history contents need not be cleared.

Configuration
REQ-026 With FLOW_AVG_ROUND_EN defined, the block SHALL add 2 to the 34-bit sum before the shift (round half up); without it, the shift floors.

Structure
REQ-027 Shared package flow_pkg SHALL hold the uv_t typedef (two signed 32-bit fields), IMG_WIDTH/IMG_HEIGHT defaults, the Q12 fraction constant and the FSM state enum.
REQ-028 The 129-entry circular history SHALL be a sub-module flow_history_buffer, with one write port and five combinational read taps at fixed offsets: centre, up, left, right and down.

Verification
REQ-029 Reset: hold reset=0 for 3 cycles, then release -> send_val=0, send_msg=0, recv_rdy=1.
REQ-030 Constant frame u=100, v=-50, send_rdy=1 -> 4096 outputs, all {-50,100}; the first send_val appears the cycle after input 65 is accepted.
REQ-031 Impulse u=400 at (10,10), all other values 0 -> u_avg=100 at (9,10), (11,10), (10,9) and (10,11); 0 at (10,10) and everywhere else.
REQ-032 Ramp u=column index, v=0: pixel (0,63) -> u_avg=62 without FLOW_AVG_ROUND_EN, and 63 with it.
REQ-033 In RUN, drop send_rdy for 10 cycles -> send_msg holds stable, recv_rdy=0, the frame still yields 4096 outputs in order; DRAIN emits the last 65 with recv_rdy=0.
REQ-034 Assert reset after input 2000, then send a full constant frame u=7 -> 4096 outputs of u=7, with no residue from the aborted frame.

Source files
------------

// File: rtl/flow_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : flow_pkg
//  Description : Shared types and constants for the flow neighbour-average
//                stage: uv flow vector type, default frame geometry, Q20.12
//                fraction constants, FSM state enum and the 4-neighbour
//                average helper. Optional macro FLOW_AVG_ROUND_EN selects
//                round-half-up instead of floor in the average.
//  Revision    : 1.0 - initial release
// ============================================================================
package flow_pkg;

    // Default frame geometry
    localparam int IMG_WIDTH_DEF  = 64;
    localparam int IMG_HEIGHT_DEF = 64;

    // Q20.12 fixed point: 12 fraction bits
    localparam int Q12_FRAC_BITS = 12;
    localparam int Q12_ONE       = 1 << Q12_FRAC_BITS;

    // Flow vector, packed as {v, u} to match the 64-bit message layout
    typedef struct packed {
        logic signed [31:0] v;
        logic signed [31:0] u;
    } uv_t;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } flow_state_t;

    // Average of four signed samples: 34-bit sum, optional +2, arithmetic
    // shift by two, truncated back to 32 bits.
    function automatic logic signed [31:0] avg4(
        input logic signed [31:0] a,
        input logic signed [31:0] b,
        input logic signed [31:0] c,
        input logic signed [31:0] d
    );
        logic signed [33:0] sum;
        logic signed [33:0] shifted;
        sum = 34'(a) + 34'(b) + 34'(c) + 34'(d);
`ifdef FLOW_AVG_ROUND_EN
        sum = sum + 34'sd2;
`endif
        shifted = sum >>> 2;
        return shifted[31:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/flow_history_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : flow_history_buffer
//  Description : Circular history of the latest 2*IMG_WIDTH+1 flow samples
//                with one write port and five combinational read taps
//                (centre, up, left, right, down) at fixed offsets behind
//                the pointer. The pointer names the slot written next, so
//                the newest sample sits at ptr-1 and the oldest at ptr.
//  Revision    : 1.0 - initial release
// ============================================================================
module flow_history_buffer
    import flow_pkg::*;
#(
    parameter int IMG_WIDTH = IMG_WIDTH_DEF,
    parameter int DEPTH     = 2 * IMG_WIDTH + 1,
    parameter int PW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [PW-1:0] ptr,
    input  uv_t           wr_data,
    output uv_t           tap_centre,
    output uv_t           tap_up,
    output uv_t           tap_left,
    output uv_t           tap_right,
    output uv_t           tap_down
);

    uv_t mem [DEPTH];

    // Slot 'off' entries behind ptr, modulo DEPTH
    function automatic logic [PW-1:0] back(input logic [PW-1:0] p, input int off);
        int t;
        t = int'(p) - off;
        if (t < 0) t = t + DEPTH;
        return PW'(t);
    endfunction

    // Write port; contents are not reset, stale data is never observed
    always_ff @(posedge clk) begin
        if (wr_en) mem[ptr] <= wr_data;
    end

    // Taps relative to the pixel whose down neighbour is the newest sample
    always_comb begin
        tap_down   = mem[back(ptr, 1)];
        tap_right  = mem[back(ptr, IMG_WIDTH)];
        tap_centre = mem[back(ptr, IMG_WIDTH + 1)];
        tap_left   = mem[back(ptr, IMG_WIDTH + 2)];
        tap_up     = mem[ptr];
    end

endmodule
`default_nettype wire

// File: rtl/flow_average.sv
`default_nettype none
// ============================================================================
//  Module      : flow_average
//  Description : Streams a frame of flow vectors in raster order and emits,
//                for every pixel, the average of its four neighbours with
//                replicated borders. FILL primes the history, RUN emits one
//                output per accepted input, DRAIN flushes the final
//                IMG_WIDTH+1 pixels. Macro FLOW_AVG_ROUND_EN enables
//                round-half-up in the average (floor otherwise).
//  Revision    : 1.0 - initial release
// ============================================================================
module flow_average
    import flow_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] recv_msg,
    input  logic        recv_val,
    output logic        recv_rdy,
    output logic [63:0] send_msg,
    output logic        send_val,
    input  logic        send_rdy
);

    localparam int NPIX  = IMG_WIDTH * IMG_HEIGHT;
    localparam int DEPTH = 2 * IMG_WIDTH + 1;
    localparam int PW    = $clog2(DEPTH);
    localparam int IW    = $clog2(NPIX);
    localparam int CW    = $clog2(IMG_WIDTH);
    localparam int RW    = $clog2(IMG_HEIGHT);

    localparam logic [IW-1:0] FILL_LAST = IW'(IMG_WIDTH);
    localparam logic [IW-1:0] IN_LAST   = IW'(NPIX - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
    localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);

    flow_state_t   state, state_next;
    logic [PW-1:0] ptr;
    logic [IW-1:0] in_cnt;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          gen_done;
    logic          accept;
    logic          gen;
    logic          frame_end;

    uv_t tap_centre, tap_up, tap_left, tap_right, tap_down;
    uv_t nb_up, nb_dn, nb_lt, nb_rt;
    uv_t avg_out;

    flow_history_buffer #(
        .IMG_WIDTH (IMG_WIDTH)
    ) u_history (
        .clk        (clk),
        .wr_en      (accept),
        .ptr        (ptr),
        .wr_data    (recv_msg),
        .tap_centre (tap_centre),
        .tap_up     (tap_up),
        .tap_left   (tap_left),
        .tap_right  (tap_right),
        .tap_down   (tap_down)
    );

    // Replicate the centre for neighbours outside the frame, then average
    always_comb begin
        nb_up     = (row == '0)       ? tap_centre : tap_up;
        nb_dn     = (row == ROW_LAST) ? tap_centre : tap_down;
        nb_lt     = (col == '0)       ? tap_centre : tap_left;
        nb_rt     = (col == COL_LAST) ? tap_centre : tap_right;
        avg_out.u = avg4(nb_up.u, nb_dn.u, nb_lt.u, nb_rt.u);
        avg_out.v = avg4(nb_up.v, nb_dn.v, nb_lt.v, nb_rt.v);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state <= ST_FILL;
        else        state <= state_next;
    end

    // Next state, input ready and output-generation strobe
    always_comb begin
        state_next = state;
        recv_rdy   = 1'b0;
        gen        = 1'b0;
        frame_end  = 1'b0;
        case (state)
            ST_FILL: begin
                recv_rdy = 1'b1;
                if (recv_val && in_cnt == FILL_LAST) state_next = ST_RUN;
            end
            ST_RUN: begin
                recv_rdy = !send_val || send_rdy;
                gen      = recv_val && recv_rdy;
                if (gen && in_cnt == IN_LAST) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                gen       = (!send_val || send_rdy) && !gen_done;
                frame_end = gen_done && send_val && send_rdy;
                if (frame_end) state_next = ST_FILL;
            end
            default: state_next = ST_FILL;
        endcase
    end

    assign accept = recv_val && recv_rdy;

    // Pointers, pixel counters and the output register
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr      <= '0;
            in_cnt   <= '0;
            col      <= '0;
            row      <= '0;
            gen_done <= 1'b0;
            send_val <= 1'b0;
            send_msg <= '0;
        end else if (frame_end) begin
            ptr      <= '0;
            in_cnt   <= '0;
            col      <= '0;
            row      <= '0;
            gen_done <= 1'b0;
            send_val <= 1'b0;
        end else begin
            // In DRAIN the pointer keeps advancing without writes so the
            // taps stay aligned to the pixel being emitted.
            if (accept || gen) ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
            if (accept) in_cnt <= in_cnt + 1'b1;
            if (gen) begin
                send_msg <= avg_out;
                send_val <= 1'b1;
                gen_done <= (row == ROW_LAST) && (col == COL_LAST);
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end else if (send_val && send_rdy) begin
                send_val <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_flow_average.sv
`default_nettype none
// ============================================================================
//  Module      : tb_flow_average
//  Description : Self-checking bench for flow_average. Frames are built in
//                an array, expected outputs come from a direct 2-D
//                neighbour-average model, and handshakes are observed every
//                cycle half a period away from the active edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_flow_average;

    localparam int W     = 64;
    localparam int H     = 64;
    localparam int N     = W * H;
    localparam int LIMIT = 8 * N + 2000;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] recv_msg;
    logic        recv_val;
    logic        recv_rdy;
    logic [63:0] send_msg;
    logic        send_val;
    logic        send_rdy;

    int checks = 0;
    int errors = 0;

    logic [63:0] frame [0:N-1];
    logic [63:0] outs  [0:N-1];

    flow_average #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .recv_msg (recv_msg),
        .recv_val (recv_val),
        .recv_rdy (recv_rdy),
        .send_msg (send_msg),
        .send_val (send_val),
        .send_rdy (send_rdy)
    );

    always #5 clk = ~clk;

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic longint fu(input int i);
        return longint'($signed(frame[i][31:0]));
    endfunction

    function automatic longint fv(input int i);
        return longint'($signed(frame[i][63:32]));
    endfunction

    function automatic logic [31:0] avg_model(input longint a, input longint b,
                                              input longint c, input longint d);
        longint s;
        s = a + b + c + d;
`ifdef FLOW_AVG_ROUND_EN
        s = s + 2;
`endif
        s = s >>> 2;
        return s[31:0];
    endfunction

    // Expected {v_avg, u_avg} for pixel p, borders replicate the centre
    function automatic logic [63:0] model_px(input int p);
        int r, c, iu, id, il, ir;
        r  = p / W;
        c  = p % W;
        iu = (r > 0)     ? p - W : p;
        id = (r < H - 1) ? p + W : p;
        il = (c > 0)     ? p - 1 : p;
        ir = (c < W - 1) ? p + 1 : p;
        return {avg_model(fv(iu), fv(id), fv(il), fv(ir)),
                avg_model(fu(iu), fu(id), fu(il), fu(ir))};
    endfunction

    task automatic fill_const(input int u, input int v);
        for (int i = 0; i < N; i++) frame[i] = {v[31:0], u[31:0]};
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) frame[i] = {$urandom(), $urandom()};
    endtask

    // bp_mode 0: always ready; 1: send_rdy low for 10 cycles once mid-frame;
    // 2: random valid/ready. abort_at >= 0 stops after that input index.
    task automatic run_frame(input int bp_mode, input int abort_at);
        int sent, got, cyc, drop;
        bit dropped, first_seen, hold_prev, acc, xfer;
        logic [63:0] hold_msg;
        sent = 0; got = 0; cyc = 0; drop = 0;
        dropped = 0; first_seen = 0; hold_prev = 0; hold_msg = '0;
        while (got < N && cyc < LIMIT && !(abort_at >= 0 && sent > abort_at)) begin
            recv_val = (sent < N) && (bp_mode != 2 || $urandom_range(0, 3) != 0);
            recv_msg = (sent < N) ? frame[sent] : 64'h0;
            if (bp_mode == 1 && sent == 1000 && !dropped) begin
                dropped = 1;
                drop    = 10;
            end
            if (bp_mode == 2) send_rdy = ($urandom_range(0, 3) != 0);
            else              send_rdy = (drop == 0);
            if (drop > 0) drop--;
            #1;
            if (hold_prev) begin
                check64("hold_val", {63'h0, send_val}, 64'h1);
                check64("hold_msg", send_msg, hold_msg);
            end
            if (send_val && !send_rdy)
                check64("bp_recv_rdy", {63'h0, recv_rdy}, 64'h0);
            if (sent == N)
                check64("drain_recv_rdy", {63'h0, recv_rdy}, 64'h0);
            if (send_val && !first_seen) begin
                first_seen = 1;
                if (bp_mode == 0) check64("first_valid_at", 64'(sent), 64'(W + 2));
            end
            acc  = recv_val && recv_rdy;
            xfer = send_val && send_rdy;
            if (xfer) begin
                outs[got] = send_msg;
                check64("pixel", send_msg, model_px(got));
                got++;
            end
            hold_prev = send_val && !send_rdy;
            hold_msg  = send_msg;
            if (acc) sent++;
            cyc++;
            @(negedge clk);
        end
        recv_val = 1'b0;
        if (abort_at < 0) check64("frame_outputs", 64'(got), 64'(N));
        else              check64("abort_inputs", 64'(sent), 64'(abort_at + 1));
    endtask

    initial begin
        logic [31:0] ramp_exp;
        reset    = 1'b0;
        recv_val = 1'b0;
        recv_msg = '0;
        send_rdy = 1'b0;

        // Reset held for three edges, then released
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check64("reset_send_val", {63'h0, send_val}, 64'h0);
        check64("reset_send_msg", send_msg, 64'h0);
        check64("reset_recv_rdy", {63'h0, recv_rdy}, 64'h1);
        @(negedge clk);

        // Constant frame
        fill_const(100, -50);
        run_frame(0, -1);
        check64("const_first", outs[0], {32'hFFFF_FFCE, 32'd100});
        check64("const_last", outs[N-1], {32'hFFFF_FFCE, 32'd100});

        // Impulse at (10,10)
        fill_const(0, 0);
        frame[10*W + 10] = {32'h0, 32'd400};
        run_frame(0, -1);
        check64("imp_up",     outs[9*W + 10],  {32'h0, 32'd100});
        check64("imp_down",   outs[11*W + 10], {32'h0, 32'd100});
        check64("imp_left",   outs[10*W + 9],  {32'h0, 32'd100});
        check64("imp_right",  outs[10*W + 11], {32'h0, 32'd100});
        check64("imp_centre", outs[10*W + 10], 64'h0);
        check64("imp_far",    outs[0],         64'h0);

        // Ramp u = column
        for (int i = 0; i < N; i++) frame[i] = {32'h0, 32'(i % W)};
        run_frame(0, -1);
`ifdef FLOW_AVG_ROUND_EN
        ramp_exp = 32'd63;
`else
        ramp_exp = 32'd62;
`endif
        check64("ramp_0_63", outs[W-1], {32'h0, ramp_exp});

        // Ten-cycle backpressure hole, random data
        fill_random();
        run_frame(1, -1);

        // Fully random handshakes, random data
        fill_random();
        run_frame(2, -1);

        // Abort after input 2000, then a clean constant frame
        fill_random();
        run_frame(2, 2000);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check64("abort_send_val", {63'h0, send_val}, 64'h0);
        check64("abort_recv_rdy", {63'h0, recv_rdy}, 64'h1);
        @(negedge clk);
        fill_const(7, 0);
        run_frame(0, -1);
        check64("after_abort_first", outs[0], {32'h0, 32'd7});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
